spike_decoder: RTL and testbench
================================

# spike_decoder

Decodes the spike trains of the presynaptic and postsynaptic LIF neurons back into numbers. It produces two result streams: per-window firing-rate counts, and pre/post spike-pair timing events (signed Δt) for the STDP weight-update logic. It sits downstream of the two `lif` instances and upstream of the STDP rule/weight register, forming the receive side of the neuron spike interface.

## Interface
- `WINDOW`, default 64: rate-measurement window length in cycles (≥2).
- `CNT_W`, default 8: width of the rate counts.
- `DT_W`, default 4: width of Δt. `DT_MAX = 2**DT_W - 1` is the pairing horizon.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pre_spike`  in  1  presynaptic spike, one-cycle pulse per spike.
- `post_spike`  in  1  postsynaptic spike, one-cycle pulse per spike.
- `ev_valid`  out  1  timing event available.
- `ev_ready`  in  1  consumer accepts the event when `ev_valid && ev_ready`.
- `ev_ltp`  out  1  1 means pre before/with post (potentiate); 0 means post before pre (depress).
- `ev_dt`  out  DT_W  magnitude of the spike separation in cycles.
- `ev_drop`  out  1  sticky flag: at least one event was lost.
- `rate_valid`  out  1  one-cycle pulse at each window end.
- `rate_pre`, `rate_post`  out  CNT_W each  spike counts of the last completed window. Held until the next window end.

## Operation
- **Per-neuron timer `t_x`** (x = pre, post):
  - On a spike, `t_x` loads 1 and `armed_x` sets.
  - Otherwise, while armed, `t_x` increments. When it reaches `DT_MAX`, `armed_x` clears.
  - Maximum reportable `ev_dt` is therefore `DT_MAX-1`.
- **Pairing**, evaluated on the values before the same-cycle update:
  - `post_spike` alone with `armed_pre`: generate an event with ltp=1, dt=`t_pre`. Then clear `armed_pre`, so each spike pairs at most once (nearest-neighbour).
  - `pre_spike` alone with `armed_post`: generate an event with ltp=0, dt=`t_post`. Then clear `armed_post`.
  - `pre_spike` and `post_spike` together: generate one event with ltp=1, dt=0. Both armed flags end cleared; this pair is consumed.
  - A spike with the opposite side unarmed generates no event and only arms its own timer.
- **Event register** (single entry):
  - A generated event loads when `!ev_valid` or `ev_ready`. This includes the same cycle the old event is accepted, which is not a drop.
  - If `ev_valid && !ev_ready`, the new event is discarded, `ev_drop` sets and stays set until `rst`, and the held event is unchanged.
  - `ev_valid` clears on handshake when no new event is generated.
- **Rate counting**:
  - `win_cnt` runs 0..WINDOW-1 and wraps.
  - Accumulators count spikes and saturate at `2**CNT_W-1`.
  - In the cycle `win_cnt == WINDOW-1`:
    - `rate_pre`/`rate_post` load the accumulator plus that cycle's spike (saturating).
    - `rate_valid` pulses on the next cycle.
    - The accumulators restart at 0.
  - `rate_valid` has no backpressure.
- **Reset**: every output is 0; all timers, armed flags, accumulators and `win_cnt` are 0. `rst` mid-operation discards the pending event and the partial window; the first window after reset is a full `WINDOW` cycles.

## Timing
- Event latency: spike in cycle n → `ev_valid`/`ev_dt`/`ev_ltp` registered, visible in cycle n+1.
- Example: pre at cycle 0, post at cycle 5 → event ltp=1, dt=5, valid from cycle 6.
- Event throughput: one per cycle when `ev_ready` is held high.
- Rate latency: window of cycles k·WINDOW..k·WINDOW+WINDOW-1 → `rate_valid` high in cycle (k+1)·WINDOW, with the new counts visible that cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `snn_pkg` holds:
  - `DT_W` and `CNT_W` defaults;
  - the `EV_LTP`=1 / `EV_LTD`=0 constants;
  - a packed event struct {ltp, dt}, shared with the STDP rule block.
- One sub-module, `spike_timer` (parameter `DT_W`; ports `spike`, `clear`, `t`, `armed`), instantiated twice, once for pre and once for post.
- Pairing, event register and rate counters stay in `spike_decoder`.

## Test plan
1. Pre at cycle 10, post at cycle 13, `ev_ready`=1 → one event, ltp=1, dt=3, `ev_valid` high only in cycle 14.
2. Post at cycle 10, pre at cycle 12 → event ltp=0, dt=2. Then pre again at cycle 20 → no event (post consumed).
3. Pre and post together at cycle 5 → single event, ltp=1, dt=0. Post at cycle 7 → no event.
4. With DT_W=4: pre at cycle 0, post at cycle 15 → no event. Post at cycle 14 instead → event dt=14.
5. `ev_ready`=0, two pairs completed → first event held, `ev_drop`=1. Release `ev_ready` → first event accepted, `ev_valid`=0 next cycle, `ev_drop` stays 1 until `rst`.
6. With WINDOW=64 and CNT_W=8:
   - Pre every cycle and post every 4th cycle → `rate_pre`=64, `rate_post`=16, `rate_valid` pulse at cycle 64.
   - With CNT_W=4, the pre count saturates at 15.
   - `rst` at cycle 30 → all outputs 0 next cycle and the next window ends at cycle 31+64.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, event polarity constants and event type for the spike decoder and STDP rule.
package snn_pkg;
  localparam int DT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic EV_LTP = 1'b1;
  localparam logic EV_LTD = 1'b0;
  typedef struct packed {
    logic ltp;
    logic [DT_W_DEF-1:0] dt;
  } ev_t;
endpackage

// File: rtl/spike_timer.sv
// spike_timer: cycles-since-last-spike counter, armed until the pairing horizon or until consumed.
module spike_timer #(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spike,
  input  logic            clear,
  output logic [DT_W-1:0] t,
  output logic            armed
);
  localparam logic [DT_W-1:0] T_LAST = DT_W'((1 << DT_W) - 2);
  // clear wins over spike so a simultaneous pre/post pair leaves both sides disarmed
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      armed <= 1'b0;
    end else if (spike) begin
      t <= DT_W'(1);
      armed <= 1'b1;
    end else if (armed) begin
      t <= t + 1'b1;
      armed <= t != T_LAST;
    end
  end
endmodule

// File: rtl/spike_decoder.sv
// spike_decoder: turns pre/post spike trains into windowed rate counts and nearest-neighbour STDP timing events.
module spike_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_spike,
  input  logic             post_spike,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_ltp,
  output logic [DT_W-1:0]  ev_dt,
  output logic             ev_drop,
  output logic             rate_valid,
  output logic [CNT_W-1:0] rate_pre,
  output logic [CNT_W-1:0] rate_post
);
  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [DT_W-1:0] w_t_pre, w_t_post;
  logic w_armed_pre, w_armed_post, w_gen, w_ltp, w_load, w_win_end;
  logic [DT_W-1:0] w_dt;
  logic [CNT_W-1:0] r_acc_pre, r_acc_post, w_nx_pre, w_nx_post;
  logic [WIN_W-1:0] r_win;
  spike_timer #(.DT_W(DT_W)) u_pre (
    .clk(clk), .rst(rst), .spike(pre_spike), .clear(post_spike), .t(w_t_pre), .armed(w_armed_pre)
  );
  spike_timer #(.DT_W(DT_W)) u_post (
    .clk(clk), .rst(rst), .spike(post_spike), .clear(pre_spike), .t(w_t_post), .armed(w_armed_post)
  );
  always_comb begin
    w_gen = (pre_spike & post_spike) | (post_spike & w_armed_pre) | (pre_spike & w_armed_post);
    w_ltp = post_spike ? EV_LTP : EV_LTD;
    w_dt = (pre_spike & post_spike) ? '0 : post_spike ? w_t_pre : w_t_post;
    w_load = w_gen & (~ev_valid | ev_ready);
    w_win_end = r_win == WIN_W'(WINDOW - 1);
    w_nx_pre = (r_acc_pre == CMAX) ? r_acc_pre : r_acc_pre + CNT_W'(pre_spike);
    w_nx_post = (r_acc_post == CMAX) ? r_acc_post : r_acc_post + CNT_W'(post_spike);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_ltp <= 1'b0;
      ev_dt <= '0;
      ev_drop <= 1'b0;
      rate_valid <= 1'b0;
      rate_pre <= '0;
      rate_post <= '0;
      r_acc_pre <= '0;
      r_acc_post <= '0;
      r_win <= '0;
    end else begin
      if (w_load) begin
        ev_ltp <= w_ltp;
        ev_dt <= w_dt;
      end
      ev_valid <= w_load | (ev_valid & ~ev_ready);
      ev_drop <= ev_drop | (w_gen & ev_valid & ~ev_ready);
      if (w_win_end) begin
        rate_pre <= w_nx_pre;
        rate_post <= w_nx_post;
      end
      rate_valid <= w_win_end;
      r_acc_pre <= w_win_end ? '0 : w_nx_pre;
      r_acc_post <= w_win_end ? '0 : w_nx_post;
      r_win <= w_win_end ? '0 : r_win + 1'b1;
    end
  end
endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder: directed plus random stimulus against a spike-time reference model.
module tb_spike_decoder;
  localparam int DTM = 15;
  logic clk = 1'b0, rst = 1'b1, pre_spike = 1'b0, post_spike = 1'b0, ev_ready = 1'b0;
  logic ev_valid, ev_ltp, ev_drop, rate_valid;
  logic [3:0] ev_dt;
  logic [7:0] rate_pre, rate_post;
  logic s_ev_valid, s_ev_ltp, s_ev_drop, s_rate_valid;
  logic [3:0] s_ev_dt, s_rate_pre, s_rate_post;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int lp, lq, cp, cq, md, mrp, mrq;
  bit pl, ql, mv, ml, mdrop, mrv;
  always #5 clk = ~clk;
  spike_decoder dut (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ltp(ev_ltp), .ev_dt(ev_dt), .ev_drop(ev_drop),
    .rate_valid(rate_valid), .rate_pre(rate_pre), .rate_post(rate_post)
  );
  spike_decoder #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .ev_valid(s_ev_valid), .ev_ready(ev_ready), .ev_ltp(s_ev_ltp), .ev_dt(s_ev_dt), .ev_drop(s_ev_drop),
    .rate_valid(s_rate_valid), .rate_pre(s_rate_pre), .rate_post(s_rate_post)
  );
  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("ev_valid", 32'(ev_valid), 32'(mv));
    chk("ev_ltp", 32'(ev_ltp), 32'(ml));
    chk("ev_dt", 32'(ev_dt), md);
    chk("ev_drop", 32'(ev_drop), 32'(mdrop));
    chk("rate_valid", 32'(rate_valid), 32'(mrv));
    chk("rate_pre", 32'(rate_pre), sat(mrp, 255));
    chk("rate_post", 32'(rate_post), sat(mrq, 255));
    chk("sat_rate_pre", 32'(s_rate_pre), sat(mrp, 15));
    chk("sat_rate_post", 32'(s_rate_post), sat(mrq, 15));
    chk("sat_ev_valid", 32'(s_ev_valid), 32'(mv));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    pre_spike = 1'b0;
    post_spike = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    {pl, ql, mv, ml, mdrop, mrv} = '0;
    {lp, lq, cp, cq, md, mrp, mrq} = '0;
    cyc = 0;
    check_all();
  endtask
  task automatic step(input bit p, input bit q, input bit r);
    bit g = 0, l = 0;
    int d = 0;
    pre_spike = p;
    post_spike = q;
    ev_ready = r;
    if (p && q) begin
      g = 1; l = 1; d = 0; pl = 0; ql = 0;
    end else if (q) begin
      if (pl && cyc - lp < DTM) begin g = 1; l = 1; d = cyc - lp; end
      pl = 0; lq = cyc; ql = 1;
    end else if (p) begin
      if (ql && cyc - lq < DTM) begin g = 1; l = 0; d = cyc - lq; end
      ql = 0; lp = cyc; pl = 1;
    end
    if (g) begin
      if (!mv || r) begin mv = 1; ml = l; md = d; end
      else mdrop = 1;
    end else if (r) mv = 0;
    cp += int'(p);
    cq += int'(q);
    mrv = (cyc % 64) == 63;
    if (mrv) begin mrp = cp; mrq = cq; cp = 0; cq = 0; end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask
  task automatic idle_to(input int c);
    while (cyc < c) step(0, 0, 1);
  endtask
  initial begin
    do_reset();
    chk("reset_ev_valid", 32'(ev_valid), 0);
    chk("reset_rate_pre", 32'(rate_pre), 0);
    idle_to(10); step(1, 0, 1); idle_to(13); step(0, 1, 1);
    chk("t1_valid", 32'(ev_valid), 1);
    chk("t1_ltp", 32'(ev_ltp), 1);
    chk("t1_dt", 32'(ev_dt), 3);
    step(0, 0, 1);
    chk("t1_valid_off", 32'(ev_valid), 0);
    do_reset();
    idle_to(10); step(0, 1, 1); idle_to(12); step(1, 0, 1);
    chk("t2_ltp", 32'(ev_ltp), 0);
    chk("t2_dt", 32'(ev_dt), 2);
    idle_to(20); step(1, 0, 1);
    chk("t2_no_event", 32'(ev_valid), 0);
    do_reset();
    idle_to(5); step(1, 1, 1);
    chk("t3_valid", 32'(ev_valid), 1);
    chk("t3_dt", 32'(ev_dt), 0);
    idle_to(7); step(0, 1, 1);
    chk("t3_no_event", 32'(ev_valid), 0);
    do_reset();
    step(1, 0, 1); idle_to(15); step(0, 1, 1);
    chk("t4_horizon", 32'(ev_valid), 0);
    do_reset();
    step(1, 0, 1); idle_to(14); step(0, 1, 1);
    chk("t4_valid", 32'(ev_valid), 1);
    chk("t4_dt", 32'(ev_dt), 14);
    do_reset();
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0); step(1, 0, 0);
    chk("t5_drop", 32'(ev_drop), 1);
    chk("t5_held_dt", 32'(ev_dt), 2);
    chk("t5_held_ltp", 32'(ev_ltp), 1);
    step(0, 0, 1);
    chk("t5_accepted", 32'(ev_valid), 0);
    idle_to(12);
    chk("t5_drop_sticky", 32'(ev_drop), 1);
    do_reset();
    for (int i = 0; i < 64; i++) step(1, i % 4 == 0, 1);
    chk("t6_rate_valid", 32'(rate_valid), 1);
    chk("t6_rate_pre", 32'(rate_pre), 64);
    chk("t6_rate_post", 32'(rate_post), 16);
    chk("t6_sat_pre", 32'(s_rate_pre), 15);
    do_reset();
    for (int i = 0; i < 30; i++) step(1, i % 4 == 0, 1);
    do_reset();
    chk("t6_rst_rate_pre", 32'(rate_pre), 0);
    chk("t6_rst_valid", 32'(rate_valid), 0);
    for (int i = 0; i < 63; i++) step(i % 3 == 0, i % 5 == 0, 1);
    chk("t6_no_early_end", 32'(rate_valid), 0);
    step(0, 0, 1);
    chk("t6_window_end", 32'(rate_valid), 1);
    chk("t6_rate_post_after_rst", 32'(rate_post), 13);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
